// File: rtl/approx_mult_err_pkg.sv
// approx_mult_err_pkg: shared widths, state encoding and saturating add for the error monitor
package approx_mult_err_pkg;
  localparam int OP_W = 8;
  localparam int PROD_W = 16;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
  // Saturating unsigned add clamped to a w-bit ceiling (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [31:0] inc, input int w);
    logic [32:0] s;
    logic [32:0] m;
    s = {1'b0, acc} + {1'b0, inc};
    m = (33'd1 << w) - 33'd1;
    return s > m ? m[31:0] : s[31:0];
  endfunction
endpackage

// File: rtl/mult8_exact_ref.sv
// mult8_exact_ref: combinational golden 8x8 unsigned multiply
//   a, b : operands (OP_W)
//   p    : exact product (PROD_W)
module mult8_exact_ref
  import approx_mult_err_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p
);
  assign p = PROD_W'(a) * PROD_W'(b);
endmodule

// File: rtl/approx_mult_err_monitor.sv
// approx_mult_err_monitor: windowed error statistics of an approximate 8x8 multiplier
//   clk, rst_n            : clock, synchronous active-low reset
//   start                 : open a new window (IDLE only)
//   in_valid / in_ready   : sample handshake for a_in, b_in, p_approx
//   busy, done            : window in progress / one-cycle results-valid pulse
//   err_count, err_sum, err_max, med : window results, held until the next done
//   err_bias              : signed saturating sum of (p_approx - exact), only with ERR_BIAS_EN
module approx_mult_err_monitor
  import approx_mult_err_pkg::*;
#(
  parameter int N_SAMPLES = 256,
  parameter int ACC_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a_in,
  input  logic [OP_W-1:0]   b_in,
  input  logic [PROD_W-1:0] p_approx,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_count,
  output logic [ACC_W-1:0]  err_sum,
  output logic [PROD_W-1:0] err_max,
  output logic [15:0]       med
`ifdef ERR_BIAS_EN
  ,
  output logic signed [ACC_W:0] err_bias
`endif
);
  localparam int LOG2N = $clog2(N_SAMPLES);
  localparam int CNT_W = LOG2N + 1;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [PROD_W-1:0] exact, s1_exact, s1_approx, diff;
  logic s1_v, accept, last;
  logic [15:0] acc_cnt;
  logic [ACC_W-1:0] acc_sum;
  logic [PROD_W-1:0] acc_max;
  logic [ACC_W+PROD_W-1:0] sum_sh;
  mult8_exact_ref u_ref (.a(a_in), .b(b_in), .p(exact));
  always_comb begin
    in_ready = state == ACCUM && cnt < CNT_W'(N_SAMPLES);
    accept = in_valid && in_ready;
    last = accept && cnt == CNT_W'(N_SAMPLES - 1);
    state_nx = state == IDLE  ? (start ? ACCUM : IDLE) :
               state == ACCUM ? (last ? DRAIN : ACCUM) :
               state == DRAIN ? (s1_v ? DRAIN : DONE) : IDLE;
    busy = state == ACCUM || state == DRAIN;
    done = state == DONE;
    diff = s1_exact >= s1_approx ? s1_exact - s1_approx : s1_approx - s1_exact;
    sum_sh = {{PROD_W{1'b0}}, acc_sum} >> LOG2N;
  end
  // Results load on the edge leaving DRAIN, once S2 has absorbed the last sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      s1_v <= 1'b0;
      s1_exact <= '0;
      s1_approx <= '0;
      acc_cnt <= '0;
      acc_sum <= '0;
      acc_max <= '0;
      err_count <= '0;
      err_sum <= '0;
      err_max <= '0;
      med <= '0;
    end else begin
      state <= state_nx;
      s1_v <= accept;
      if (accept) begin
        cnt <= cnt + 1'b1;
        s1_exact <= exact;
        s1_approx <= p_approx;
      end
      if (s1_v) begin
        acc_cnt <= acc_cnt + 16'(diff != '0);
        acc_sum <= ACC_W'(sat_add(32'(acc_sum), 32'(diff), ACC_W));
        acc_max <= diff > acc_max ? diff : acc_max;
      end
      if (state == IDLE && start) begin
        cnt <= '0;
        s1_v <= 1'b0;
        acc_cnt <= '0;
        acc_sum <= '0;
        acc_max <= '0;
      end
      if (state == DRAIN && !s1_v) begin
        err_count <= acc_cnt;
        err_sum <= acc_sum;
        err_max <= acc_max;
        med <= sum_sh[15:0];
      end
    end
  end
`ifdef ERR_BIAS_EN
  localparam int BW = (ACC_W + 2 > PROD_W + 2) ? ACC_W + 2 : PROD_W + 2;
  localparam logic signed [BW-1:0] B_HI = (BW'(1) << ACC_W) - BW'(1);
  localparam logic signed [BW-1:0] B_LO = -(BW'(1) << ACC_W);
  logic signed [PROD_W:0] s1_delta;
  logic signed [ACC_W:0] acc_bias;
  logic signed [BW-1:0] bias_nx;
  always_comb begin
    bias_nx = BW'(acc_bias) + BW'(s1_delta);
    bias_nx = bias_nx > B_HI ? B_HI : bias_nx < B_LO ? B_LO : bias_nx;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_delta <= '0;
      acc_bias <= '0;
      err_bias <= '0;
    end else begin
      if (accept) s1_delta <= $signed({1'b0, p_approx}) - $signed({1'b0, exact});
      if (s1_v) acc_bias <= bias_nx[ACC_W:0];
      if (state == IDLE && start) acc_bias <= '0;
      if (state == DRAIN && !s1_v) err_bias <= acc_bias;
    end
  end
`endif
endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// tb_approx_mult_err_monitor: randomized and directed checks of the error monitor against a reference model
module tb_approx_mult_err_monitor;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n, start, in_valid;
  logic [7:0] a_in, b_in;
  logic [15:0] p_approx;
  logic rdy0, busy0, done0, rdy1, busy1, done1;
  logic [15:0] cnt0, max0, med0, cnt1, max1, med1;
  logic [23:0] sum0;
  logic [7:0] sum1;
  int checks = 0, errors = 0;
  int sa[N], sb[N], sp[N];
  int e_cnt, e_max, e_sum0, e_sum1, e_med0, e_med1;
  always #5 clk = ~clk;
  approx_mult_err_monitor #(.N_SAMPLES(N), .ACC_W(24)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy0),
    .a_in(a_in), .b_in(b_in), .p_approx(p_approx), .busy(busy0), .done(done0),
    .err_count(cnt0), .err_sum(sum0), .err_max(max0), .med(med0));
  approx_mult_err_monitor #(.N_SAMPLES(N), .ACC_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy1),
    .a_in(a_in), .b_in(b_in), .p_approx(p_approx), .busy(busy1), .done(done1),
    .err_count(cnt1), .err_sum(sum1), .err_max(max1), .med(med1));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic void ref_model();
    longint s0 = 0, s1 = 0;
    int d;
    e_cnt = 0;
    e_max = 0;
    for (int k = 0; k < N; k++) begin
      d = sa[k] * sb[k] - sp[k];
      if (d < 0) d = -d;
      if (d != 0) e_cnt++;
      if (d > e_max) e_max = d;
      s0 = s0 + d > 64'd16777215 ? 64'd16777215 : s0 + d;
      s1 = s1 + d > 64'd255 ? 64'd255 : s1 + d;
    end
    e_sum0 = int'(s0);
    e_sum1 = int'(s1);
    e_med0 = (e_sum0 / N) % 65536;
    e_med1 = e_sum1 / N;
  endfunction
  task automatic run_window(input bit gaps, input bit extra);
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (cnt0 !== 16'(e_cnt) || sum0 !== 24'(e_sum0) || sum1 !== 8'(e_sum1) || max0 !== 16'(e_max)) begin
      errors++;
      $display("FAIL hold_prev: cnt=%0d sum0=%0d sum1=%0d max=%0d expected %0d %0d %0d %0d", cnt0, sum0, sum1, max0, e_cnt, e_sum0, e_sum1, e_max);
    end
    checks++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b/%b expected 1", busy0, busy1);
    end
    ref_model();
    for (int k = 0; k < N; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        start = 1'b1;
        a_in = 8'($urandom);
        step();
        start = 1'b0;
      end
      in_valid = 1'b1;
      a_in = 8'(sa[k]);
      b_in = 8'(sb[k]);
      p_approx = 16'(sp[k]);
      checks++;
      if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
        errors++;
        $display("FAIL in_ready_accum k=%0d: got %b/%b expected 1", k, rdy0, rdy1);
      end
      step();
    end
    in_valid = extra;
    a_in = 8'd255;
    b_in = 8'd255;
    p_approx = 16'd0;
    start = extra;
    checks++;
    if (rdy0 !== 1'b0 || rdy1 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL post_last: in_ready=%b/%b done=%b expected 0/0 0", rdy0, rdy1, done0);
    end
    step();
    in_valid = 1'b0;
    start = 1'b0;
    checks++;
    if (done0 !== 1'b0 || rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL early_done: done=%b in_ready=%b expected 0 0", done0, rdy0);
    end
    step();
    checks++;
    if (done0 !== 1'b1 || done1 !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: got %b/%b expected 1", done0, done1);
    end
    checks++;
    if (cnt0 !== 16'(e_cnt) || sum0 !== 24'(e_sum0) || max0 !== 16'(e_max) || med0 !== 16'(e_med0)) begin
      errors++;
      $display("FAIL result_acc24: cnt=%0d sum=%0d max=%0d med=%0d expected %0d %0d %0d %0d", cnt0, sum0, max0, med0, e_cnt, e_sum0, e_max, e_med0);
    end
    checks++;
    if (cnt1 !== 16'(e_cnt) || sum1 !== 8'(e_sum1) || max1 !== 16'(e_max) || med1 !== 16'(e_med1)) begin
      errors++;
      $display("FAIL result_acc8: cnt=%0d sum=%0d max=%0d med=%0d expected %0d %0d %0d %0d", cnt1, sum1, max1, med1, e_cnt, e_sum1, e_max, e_med1);
    end
    step();
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b0 || cnt0 !== 16'(e_cnt) || sum0 !== 24'(e_sum0)) begin
      errors++;
      $display("FAIL after_done: done=%b busy=%b cnt=%0d sum=%0d expected 0 0 %0d %0d", done0, busy0, cnt0, sum0, e_cnt, e_sum0);
    end
  endtask
  task automatic set_sample(input int k, input int a, input int b, input int p);
    sa[k] = a;
    sb[k] = b;
    sp[k] = p;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({rdy0, busy0, done0, cnt0, sum0, max0, med0} !== '0 || {rdy1, busy1, done1, sum1} !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b busy=%b done=%b cnt=%0d sum=%0d max=%0d med=%0d expected all 0", rdy0, busy0, done0, cnt0, sum0, max0, med0);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (rdy0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: rdy=%b busy=%b expected 0 0", rdy0, busy0);
    end
    e_cnt = 0; e_max = 0; e_sum0 = 0; e_sum1 = 0; e_med0 = 0; e_med1 = 0;
  endtask
  task automatic test_exact();
    for (int k = 0; k < N; k++) set_sample(k, 3 + k, 5, (3 + k) * 5);
    run_window(1'b0, 1'b0);
  endtask
  task automatic test_errors();
    set_sample(0, 255, 255, 65009);
    set_sample(1, 3, 5, 15);
    set_sample(2, 10, 10, 90);
    set_sample(3, 2, 2, 4);
    run_window(1'b0, 1'b0);
  endtask
  task automatic test_approx_above();
    set_sample(0, 7, 9, 63);
    set_sample(1, 1, 1, 5);
    set_sample(2, 12, 12, 144);
    set_sample(3, 0, 200, 0);
    run_window(1'b0, 1'b0);
  endtask
  task automatic test_gaps_extra();
    set_sample(0, 100, 50, 5010);
    set_sample(1, 8, 8, 60);
    set_sample(2, 255, 1, 255);
    set_sample(3, 17, 3, 40);
    run_window(1'b1, 1'b1);
  endtask
  task automatic test_reset_midwindow();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      a_in = 8'd200;
      b_in = 8'd3;
      p_approx = 16'd1;
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({rdy0, busy0, done0, cnt0, sum0, max0, med0} !== '0) begin
      errors++;
      $display("FAIL reset_midwindow: rdy=%b busy=%b done=%b cnt=%0d sum=%0d max=%0d med=%0d expected all 0", rdy0, busy0, done0, cnt0, sum0, max0, med0);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (done0 !== 1'b0 || busy0 !== 1'b0) begin
        errors++;
        $display("FAIL no_done_after_reset cycle %0d: done=%b busy=%b expected 0 0", i, done0, busy0);
      end
    end
    e_cnt = 0; e_max = 0; e_sum0 = 0; e_sum1 = 0; e_med0 = 0; e_med1 = 0;
    set_sample(0, 9, 9, 80);
    set_sample(1, 4, 4, 16);
    set_sample(2, 20, 20, 410);
    set_sample(3, 6, 7, 42);
    run_window(1'b0, 1'b0);
  endtask
  task automatic test_saturation();
    set_sample(0, 10, 20, 0);
    set_sample(1, 10, 10, 0);
    set_sample(2, 1, 1, 1);
    set_sample(3, 0, 0, 0);
    run_window(1'b0, 1'b0);
  endtask
  task automatic test_random();
    int ex, off;
    for (int w = 0; w < 8; w++) begin
      for (int k = 0; k < N; k++) begin
        sa[k] = int'($urandom_range(0, 255));
        sb[k] = int'($urandom_range(0, 255));
        ex = sa[k] * sb[k];
        off = int'($urandom_range(0, 300));
        case ($urandom_range(0, 3))
          0: sp[k] = ex;
          1: sp[k] = ex + off > 65535 ? 65535 : ex + off;
          2: sp[k] = ex - off < 0 ? 0 : ex - off;
          default: sp[k] = int'($urandom_range(0, 65535));
        endcase
      end
      run_window(w[0], w[1]);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    a_in = '0;
    b_in = '0;
    p_approx = '0;
    test_reset();
    test_exact();
    test_errors();
    test_approx_above();
    test_gaps_extra();
    test_reset_midwindow();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/approx_mult_err_monitor.md
Name: approx_mult_err_monitor

Overview:
- Downstream evaluation stage for the 8x8 approximate multipliers produced by each NSGA-II configuration.
- Consumes operand pairs and the approximate 16-bit product, computes the exact product internally, and accumulates error statistics over a fixed window.
- Reports error count, error sum, maximum error and mean error distance (MED) so each candidate can be scored in hardware.

Parameters:
- N_SAMPLES, 256, samples per window; power of two, 2..32768.
- ACC_W, 24, width of the error-sum accumulator; saturating.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  begin a new window; honoured only in IDLE.
- in_valid  in  1  sample on a_in/b_in/p_approx is valid.
- in_ready  out  1  block accepts a sample this cycle.
- a_in  in  8  multiplicand fed to the approximate multiplier.
- b_in  in  8  multiplier operand.
- p_approx  in  16  approximate product for a_in*b_in.
- busy  out  1  high in ACCUM and DRAIN.
- done  out  1  one-cycle pulse; result ports valid from this cycle on.
- err_count  out  16  samples with p_approx != exact product.
- err_sum  out  ACC_W  sum of |exact - p_approx|, saturating at 2^ACC_W-1.
- err_max  out  16  largest |exact - p_approx| in the window.
- med  out  16  err_sum >> log2(N_SAMPLES), truncated, low 16 bits.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, every output 0, all accumulators, counters and pipeline valids cleared. Reset mid-window abandons the window with no done pulse.
- Interface is one clock domain; reset is synchronous and active-low, ports named clk and rst_n.
- State machine:
  - IDLE: start=1 clears accumulators, sample counter and pipeline, then goes to ACCUM. Result ports keep the previous window's values until the next done.
  - ACCUM: in_ready=1 while accepted < N_SAMPLES. A sample is accepted when in_valid && in_ready. On the Nth accept, in_ready falls combinationally in the following cycle, and the state goes to DRAIN.
  - DRAIN: waits until pipeline stage 2 has absorbed the last sample, then goes to DONE.
  - DONE: one cycle; done=1 and results registered to the output ports; next state IDLE.
- start is ignored outside IDLE.
- Pipeline:
  - S1 registers the exact product (a_in*b_in, 16-bit unsigned) and p_approx at the accept edge.
  - S2 computes diff=|exact-p_approx| and updates the accumulators on the next edge.
  - The done cycle follows the edge at which the last S2 update occurs, so done is high 2 cycles after the edge that accepts the Nth sample.
- Arithmetic:
  - diff is 16-bit unsigned; p_approx > exact is allowed, magnitude only.
  - err_count increments when diff != 0.
  - err_max updates when diff > current value.
  - err_sum saturates and never wraps.
- in_valid gaps are legal; the counter advances only on accept. Samples offered while in_ready=0 are dropped; no stall upstream is required beyond honouring in_ready.

Optional Feature:
- Macro ERR_BIAS_EN.
- Defined: extra output err_bias (signed, ACC_W+1 bits) equal to the saturating sum of (p_approx - exact), cleared on start and registered at done.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package approx_mult_err_pkg holds:
  - OP_W=8 and PROD_W=16.
  - The state enum {IDLE, ACCUM, DRAIN, DONE}.
  - A saturating-add function.
- One sub-module, mult8_exact_ref: combinational exact 8x8 unsigned multiply feeding S1. It is kept separate so the golden model is swappable.

Test Plan:
- N_SAMPLES=4, four samples with p_approx exact (e.g. 3*5=15) -> err_count 0, err_sum 0, err_max 0, med 0; done 2 cycles after 4th accept.
- N_SAMPLES=4, samples (255,255,65009), (3,5,15), (10,10,90), (2,2,4) -> diffs 16,0,10,0; err_count 2, err_sum 26, err_max 16, med 6.
- Approx above exact: (1,1,p_approx=5) among 3 exact samples -> err_sum 4, err_max 4, err_count 1, med 1.
- in_valid toggling every other cycle plus a 5th sample offered after the 4th accept -> 5th not accepted (in_ready=0), results reflect only the first 4; start during busy ignored.
- rst_n=0 after 2 of 4 accepts -> all outputs 0, no done. Then start with 4 fresh samples -> correct results.
- ACC_W=8, N_SAMPLES=4, diffs 200,100,0,0 -> err_sum saturates at 255, med 63, err_max 200.
